// File: rtl/phase_seq_pkg.sv
// phase_seq_pkg: phase bus indices, sequencer state encoding and phase decode.
package phase_seq_pkg;
  localparam int PHASE_H = 4;
  localparam int PH_F = 0;
  localparam int PH_D = 1;
  localparam int PH_E = 2;
  localparam int PH_M = 3;
  localparam int PH_W = 4;
  typedef enum logic [2:0] {S_IDLE, S_F, S_D, S_E, S_M, S_W, S_HALT, S_ERR} state_t;
  function automatic logic [PHASE_H:0] phase_of(input state_t s);
    phase_of = '0;
    phase_of[PH_F] = s == S_F;
    phase_of[PH_D] = s == S_D;
    phase_of[PH_E] = s == S_E;
    phase_of[PH_M] = s == S_M;
    phase_of[PH_W] = s == S_W;
  endfunction
endpackage

// File: rtl/phase_seq_mem_wait_timer.sv
// mem_wait_timer: counts unacknowledged memory-wait cycles and flags the last allowed one.
module mem_wait_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic [7:0] i_timeout,
  output logic       o_expired
);
  logic [7:0] r_cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + 8'd1;
  assign o_expired = i_en && r_cnt == i_timeout - 8'd1;
endmodule

// File: rtl/phase_seq.sv
// phase_seq: multicycle one-hot phase sequencer with memory handshake timeout and retire counter.
module phase_seq
  import phase_seq_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               halt_req,
  input  logic               need_mem,
  input  logic               mem_is_write,
  input  logic               mem_ack,
  output logic [PHASE_H:0]   phase,
  output logic               mem_req,
  output logic               mem_we,
  output logic               halted,
  output logic               err_timeout,
  output logic [31:0]        retired
);
  state_t r_state, w_next;
  logic   r_need_mem, r_is_write;
  logic   w_busy, w_expired, w_retire;
  assign w_busy = r_state == S_F || r_state == S_M;
  // The counter sits cleared outside F/M, so it is always zero on entry to either.
  mem_wait_timer u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (!w_busy),
    .i_en      (w_busy && !mem_ack),
    .i_timeout (8'(TIMEOUT)),
    .o_expired (w_expired)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = run ? S_F : S_IDLE;
      S_F:     w_next = mem_ack ? S_D : w_expired ? S_ERR : S_F;
      S_D:     w_next = halt_req ? S_HALT : S_E;
      S_E:     w_next = r_need_mem ? S_M : S_W;
      S_M:     w_next = mem_ack ? S_W : w_expired ? S_ERR : S_M;
      S_W:     w_next = run ? S_F : S_IDLE;
      default: w_next = r_state;
    endcase
  end
  assign w_retire = r_state == S_W || (r_state == S_D && halt_req);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state    <= S_IDLE;
      r_need_mem <= 1'b0;
      r_is_write <= 1'b0;
      retired    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_D) begin
        r_need_mem <= need_mem;
        r_is_write <= mem_is_write;
      end
      if (w_retire) retired <= retired + 32'd1;
    end
  assign phase       = phase_of(r_state);
  assign mem_req     = w_busy;
  assign mem_we      = r_state == S_M && r_is_write;
  assign halted      = r_state == S_HALT;
  assign err_timeout = r_state == S_ERR;
endmodule

// File: tb/tb_phase_seq.sv
// tb_phase_seq: builds expected per-cycle phase traces from instruction descriptions and checks the sequencer.
module tb_phase_seq;
  localparam int TO = 4;
  localparam logic [4:0] PF = 5'b00001, PD = 5'b00010, PE = 5'b00100, PM = 5'b01000, PW = 5'b10000;
  typedef struct {
    logic [4:0] ph;
    logic we, ack, run, nm, wr, hr, hd, er, ret;
  } rec_t;
  logic clk = 0, rst = 0, run = 0, halt_req = 0, need_mem = 0, mem_is_write = 0, mem_ack = 0;
  logic [4:0] phase;
  logic mem_req, mem_we, halted, err_timeout;
  logic [31:0] retired, exp_ret;
  int n_chk = 0, n_fail = 0;
  bit dead;
  rec_t q[$];
  always #5 clk = ~clk;
  phase_seq #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .run(run), .halt_req(halt_req), .need_mem(need_mem),
    .mem_is_write(mem_is_write), .mem_ack(mem_ack), .phase(phase), .mem_req(mem_req),
    .mem_we(mem_we), .halted(halted), .err_timeout(err_timeout), .retired(retired)
  );
  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction
  task automatic add(input logic [4:0] ph, input logic we, input logic ack, input logic rn,
                     input logic nm, input logic wr, input logic hr, input logic hd,
                     input logic er, input logic ret);
    rec_t r;
    r.ph = ph; r.we = we; r.ack = ack; r.run = rn; r.nm = nm; r.wr = wr;
    r.hr = hr; r.hd = hd; r.er = er; r.ret = ret;
    q.push_back(r);
  endtask
  task automatic idle_start();
    int n;
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) add(5'b0, 0, rb(), 0, rb(), rb(), rb(), 0, 0, 0);
    add(5'b0, 0, rb(), 1, rb(), rb(), rb(), 0, 0, 0);
  endtask
  // One instruction: F waits df cycles for ack, M waits dm; a wait of TO or more times out.
  task automatic instr(input logic nm, input logic wr, input logic hr, input int df, input int dm,
                       input logic run_after);
    if (dead) return;
    for (int i = 0; i <= df && i < TO; i++) add(PF, 0, i == df, rb(), rb(), rb(), rb(), 0, 0, 0);
    if (df >= TO) begin
      for (int i = 0; i < 3; i++) add(5'b0, 0, rb(), rb(), rb(), rb(), rb(), 0, 1, 0);
      dead = 1;
      return;
    end
    add(PD, 0, rb(), rb(), nm, wr, hr, 0, 0, hr);
    if (hr) begin
      for (int i = 0; i < 3; i++) add(5'b0, 0, rb(), rb(), rb(), rb(), rb(), 1, 0, 0);
      dead = 1;
      return;
    end
    add(PE, 0, rb(), rb(), rb(), rb(), rb(), 0, 0, 0);
    if (nm) begin
      for (int i = 0; i <= dm && i < TO; i++) add(PM, wr, i == dm, rb(), rb(), rb(), rb(), 0, 0, 0);
      if (dm >= TO) begin
        for (int i = 0; i < 3; i++) add(5'b0, 0, rb(), rb(), rb(), rb(), rb(), 0, 1, 0);
        dead = 1;
        return;
      end
    end
    add(PW, 0, rb(), run_after, rb(), rb(), rb(), 0, 0, 1);
  endtask
  task automatic do_reset();
    rst = 0; run = 0; mem_ack = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    exp_ret = 0;
    dead = 0;
    q.delete();
  endtask
  task automatic run_trace(input int rst_at);
    logic [8:0] got, exp;
    foreach (q[k]) begin
      got = {phase, mem_req, mem_we, halted, err_timeout};
      exp = {q[k].ph, q[k].ph[0] | q[k].ph[3], q[k].we, q[k].hd, q[k].er};
      n_chk++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL outputs cyc%0d {phase,req,we,halted,err} got %b expected %b", k, got, exp);
      end
      n_chk++;
      if (retired !== exp_ret) begin
        n_fail++;
        $display("FAIL retired cyc%0d got %0d expected %0d", k, retired, exp_ret);
      end
      if (k == rst_at) begin
        rst = 0;
        #1;
        n_chk++;
        if ({phase, mem_req, mem_we, halted, err_timeout, retired} !== 41'b0) begin
          n_fail++;
          $display("FAIL async_reset phase %b req %b we %b retired %0d expected all zero",
                   phase, mem_req, mem_we, retired);
        end
        @(negedge clk);
        rst = 1;
        exp_ret = 0;
        break;
      end
      mem_ack = q[k].ack; run = q[k].run; need_mem = q[k].nm;
      mem_is_write = q[k].wr; halt_req = q[k].hr;
      if (q[k].ret) exp_ret++;
      @(negedge clk);
    end
    q.delete();
  endtask
  task automatic test_reset();
    rst = 0;
    #1;
    n_chk++;
    if ({phase, mem_req, mem_we, halted, err_timeout, retired} !== 41'b0) begin
      n_fail++;
      $display("FAIL reset_state phase %b req %b retired %0d expected all zero", phase, mem_req, retired);
    end
    do_reset();
    n_chk++;
    if ({phase, mem_req, mem_we, halted, err_timeout, retired} !== 41'b0) begin
      n_fail++;
      $display("FAIL reset_release phase %b req %b retired %0d expected all zero", phase, mem_req, retired);
    end
  endtask
  task automatic test_basic();
    do_reset(); idle_start();
    instr(0, 0, 0, 0, 0, 1); instr(0, 0, 0, 0, 0, 1); instr(0, 0, 0, 0, 0, 0);
    run_trace(-1);
  endtask
  task automatic test_load_store();
    do_reset(); idle_start();
    instr(1, 0, 0, 0, 3, 1); instr(1, 1, 0, 0, 0, 1); instr(1, 1, 0, 2, 1, 0);
    idle_start(); instr(0, 1, 0, 1, 0, 0);
    run_trace(-1);
  endtask
  task automatic test_timeout();
    do_reset(); idle_start(); instr(0, 0, 0, 4, 0, 0); run_trace(-1);
    do_reset(); idle_start(); instr(0, 0, 0, 3, 0, 0); run_trace(-1);
    do_reset(); idle_start(); instr(1, 0, 0, 0, 3, 1); instr(1, 1, 0, 0, 4, 0); run_trace(-1);
  endtask
  task automatic test_halt();
    do_reset(); idle_start(); instr(0, 0, 0, 0, 0, 1); instr(1, 1, 1, 0, 0, 1); run_trace(-1);
  endtask
  task automatic test_run_drop_reset();
    int b;
    do_reset(); idle_start();
    instr(1, 0, 0, 0, 0, 0);
    idle_start();
    b = q.size();
    instr(1, 0, 0, 1, 3, 1);
    run_trace(b + 5);
    idle_start(); instr(0, 0, 0, 0, 0, 0);
    run_trace(-1);
  endtask
  task automatic test_random();
    logic ra;
    for (int s = 0; s < 25; s++) begin
      do_reset(); idle_start();
      for (int j = 0; j < 6 && !dead; j++) begin
        ra = $urandom_range(0, 3) != 0;
        instr(rb(), rb(), $urandom_range(0, 7) == 0,
              $urandom_range(0, 9) == 0 ? 4 : $urandom_range(0, 3),
              $urandom_range(0, 9) == 0 ? 5 : $urandom_range(0, 3), ra);
        if (!ra && !dead) idle_start();
      end
      run_trace(-1);
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_load_store();
    test_timeout();
    test_halt();
    test_run_drop_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
